if_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register for the 32-bit MIPS core. Holds the PC, fetches from instruction memory over a req/ack handshake of variable latency, and presents `ir`/`pc_plus4`/`ir_valid` to the decode stage, which splits `ir` into register, opcode and offset fields. It also handles decode-stage stalls and branch/jump redirects, including redirects that arrive while a fetch is still outstanding.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/if_stage_if.sv | 14 +
 rtl/if_pc_sel.sv | 24 ++
 rtl/if_stage.sv | 106 ++++++++++
 tb/tb_if_stage.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core: widths, instruction field positions
// and the fetch-stage state encoding.
package cpu_pkg;

  localparam int WORD_WIDTH    = 32;
  localparam int REGADDR_WIDTH = 5;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  // Instruction field bit positions, shared with decode
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int ADDR_MSB   = 25;
  localparam int ADDR_LSB   = 0;

  typedef enum logic [1:0] {
    RUN,
    DISCARD,
    HOLD
  } if_state_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus: request/address out, ack/data back.
interface if_stage_if #(
  parameter int WORD_WIDTH = cpu_pkg::WORD_WIDTH
) ();

  logic                  req;
  logic [WORD_WIDTH-1:0] addr;
  logic                  ack;
  logic [WORD_WIDTH-1:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);

endinterface

// File: rtl/if_pc_sel.sv
// Redirect decision for the fetch stage: a resolved branch wins over a jump
// sitting in IF/ID.
module if_pc_sel (
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic        ir_valid,
  input  logic [25:0] jump_index,
  input  logic [31:0] pc_plus4,
  output logic        redirect,
  output logic [31:0] target
);

  always_comb begin
    redirect = br_taken | (jump & ir_valid);
    if (br_taken) begin
      target = br_target & ~32'h0000_0003;
    end else begin
      // J-type keeps the top nibble of the jump's own pc_plus4
      target = (pc_plus4 & 32'hF000_0000) | {4'b0000, jump_index, 2'b00};
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch with IF/ID register. An ack taken while decode stalls is
// parked in a skid buffer; a redirect during an outstanding fetch waits for
// that fetch to drain before the new target is requested.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          WORD_WIDTH = cpu_pkg::WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  br_taken,
  input  logic [WORD_WIDTH-1:0] br_target,
  input  logic                  jump,
  input  logic [25:0]           jump_index,
  if_stage_if.master            imem,
  output logic [WORD_WIDTH-1:0] ir,
  output logic [WORD_WIDTH-1:0] pc_plus4,
  output logic                  ir_valid
);

  import cpu_pkg::*;

  if_state_t             state;
  logic [WORD_WIDTH-1:0] pc;
  logic [WORD_WIDTH-1:0] pend;
  logic [WORD_WIDTH-1:0] skid;
  logic [WORD_WIDTH-1:0] pc_next4;
  logic                  redirect;
  logic [WORD_WIDTH-1:0] target;

  if_pc_sel u_pc_sel (
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jump       (jump),
    .ir_valid   (ir_valid),
    .jump_index (jump_index),
    .pc_plus4   (pc_plus4),
    .redirect   (redirect),
    .target     (target)
  );

  assign pc_next4  = pc + WORD_WIDTH'(4);
  assign imem.req  = !rst && (state != HOLD);
  assign imem.addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      pend     <= RESET_PC;
      skid     <= NOP;
      ir       <= NOP;
      pc_plus4 <= '0;
      ir_valid <= 1'b0;
    end else if (redirect) begin
      ir       <= NOP;
      ir_valid <= 1'b0;
      // Without an ack the old fetch is still in flight and must drain first
      if (state == HOLD || imem.ack) begin
        pc    <= target;
        state <= RUN;
      end else begin
        pend  <= target;
        state <= DISCARD;
      end
    end else begin
      case (state)
        RUN: begin
          if (imem.ack && !stall) begin
            ir       <= imem.rdata;
            pc_plus4 <= pc_next4;
            ir_valid <= 1'b1;
            pc       <= pc_next4;
          end else if (imem.ack) begin
            skid  <= imem.rdata;
            state <= HOLD;
          end else if (!stall) begin
            ir       <= NOP;
            ir_valid <= 1'b0;
          end
        end
        DISCARD: begin
          if (imem.ack) begin
            pc    <= pend;
            state <= RUN;
          end
          if (!stall) begin
            ir       <= NOP;
            ir_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            ir       <= skid;
            pc_plus4 <= pc_next4;
            ir_valid <= 1'b1;
            pc       <= pc_next4;
            state    <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run
// scored against an in-order instruction-stream model.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] ir;
  logic [31:0] pc_plus4;
  logic        ir_valid;

  int checks = 0;
  int errors = 0;

  int  mem_wait;
  bit  scramble;
  bit  mem_active;
  int  wait_left;

  if_stage_if #(.WORD_WIDTH(32)) imem_bus ();

  if_stage #(.RESET_PC(RESET_PC), .WORD_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jump       (jump),
    .jump_index (jump_index),
    .imem       (imem_bus),
    .ir         (ir),
    .pc_plus4   (pc_plus4),
    .ir_valid   (ir_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (scramble) return {a[15:0], a[31:16]} ^ 32'h8C3A_51E7;
    return a;
  endfunction

  // Memory model: each new request waits mem_wait cycles (random if negative)
  task automatic mem_step();
    #1;
    if (rst || !imem_bus.req) begin
      imem_bus.ack   = 1'b0;
      imem_bus.rdata = 32'h0;
      if (rst) mem_active = 1'b0;
    end else begin
      if (!mem_active) begin
        mem_active = 1'b1;
        wait_left  = (mem_wait < 0) ? int'($urandom_range(0, 3)) : mem_wait;
      end
      if (wait_left == 0) begin
        imem_bus.ack   = 1'b1;
        imem_bus.rdata = mem_data(imem_bus.addr);
        mem_active     = 1'b0;
      end else begin
        imem_bus.ack   = 1'b0;
        imem_bus.rdata = 32'hDEAD_BEEF;
        wait_left--;
      end
    end
  endtask

  task automatic next_cycle(input logic r, input logic s);
    @(negedge clk);
    rst      = r;
    stall    = s;
    br_taken = 1'b0;
    jump     = 1'b0;
    mem_step();
  endtask

  task automatic do_reset();
    next_cycle(1'b1, 1'b0);
    next_cycle(1'b1, 1'b0);
    next_cycle(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    scramble = 1'b1;
    mem_wait = 0;
    next_cycle(1'b1, 1'b0);
    checks++;
    if (imem_bus.req !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_req_low: got %b expected 0", imem_bus.req);
    end
    next_cycle(1'b1, 1'b0);
    next_cycle(1'b0, 1'b0);
    checks++;
    if (ir !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_ir: got %h expected 0", ir);
    end
    checks++;
    if (ir_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ir_valid: got %b expected 0", ir_valid);
    end
    checks++;
    if (pc_plus4 !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_pc_plus4: got %h expected 0", pc_plus4);
    end
    checks++;
    if (imem_bus.addr !== RESET_PC || imem_bus.req !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_fetch: got addr %h req %b expected addr %h req 1",
                         imem_bus.addr, imem_bus.req, RESET_PC);
    end
  endtask

  task automatic test_zero_wait();
    scramble = 1'b0;
    mem_wait = 0;
    do_reset();
    checks++;
    if (imem_bus.addr !== 32'h0 || ir_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL zw_cycle0: got addr %h valid %b expected 0/0", imem_bus.addr, ir_valid);
    end
    for (int k = 1; k <= 3; k++) begin
      next_cycle(1'b0, 1'b0);
      checks++;
      if (imem_bus.addr !== 32'(4 * k)) begin
        errors++; $display("[TB] FAIL zw_addr: got %h expected %h", imem_bus.addr, 32'(4 * k));
      end
      checks++;
      if (ir !== 32'(4 * (k - 1)) || ir_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL zw_ir: got %h/%b expected %h/1", ir, ir_valid, 32'(4 * (k - 1)));
      end
      checks++;
      if (pc_plus4 !== 32'(4 * k)) begin
        errors++; $display("[TB] FAIL zw_pc_plus4: got %h expected %h", pc_plus4, 32'(4 * k));
      end
    end
  endtask

  task automatic test_latency();
    scramble = 1'b1;
    mem_wait = 2;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h0) begin
        errors++; $display("[TB] FAIL lat_req_stable: cycle %0d got req %b addr %h expected 1/0",
                           c, imem_bus.req, imem_bus.addr);
      end
      checks++;
      if (ir_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL lat_bubble: cycle %0d got valid %b expected 0", c, ir_valid);
      end
      next_cycle(1'b0, 1'b0);
    end
    checks++;
    if (ir !== mem_data(32'h0) || ir_valid !== 1'b1 || pc_plus4 !== 32'h4) begin
      errors++; $display("[TB] FAIL lat_deliver: got %h/%b/%h expected %h/1/4",
                         ir, ir_valid, pc_plus4, mem_data(32'h0));
    end
  endtask

  task automatic test_stall_hold();
    scramble = 1'b1;
    mem_wait = 0;
    do_reset();
    for (int c = 1; c <= 3; c++) next_cycle(1'b0, 1'b0);
    next_cycle(1'b0, 1'b1);
    checks++;
    if (imem_bus.addr !== 32'h10 || ir !== mem_data(32'hC) || pc_plus4 !== 32'h10) begin
      errors++; $display("[TB] FAIL hold_entry: got addr %h ir %h pc4 %h expected 10/%h/10",
                         imem_bus.addr, ir, pc_plus4, mem_data(32'hC));
    end
    for (int c = 5; c <= 7; c++) begin
      next_cycle(1'b0, 1'b1);
      checks++;
      if (imem_bus.req !== 1'b0) begin
        errors++; $display("[TB] FAIL hold_req: cycle %0d got %b expected 0", c, imem_bus.req);
      end
      checks++;
      if (ir !== mem_data(32'hC) || pc_plus4 !== 32'h10 || ir_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL hold_ifid: got %h/%h/%b expected %h/10/1",
                           ir, pc_plus4, ir_valid, mem_data(32'hC));
      end
    end
    next_cycle(1'b0, 1'b0);
    checks++;
    if (imem_bus.req !== 1'b0) begin
      errors++; $display("[TB] FAIL hold_release_req: got %b expected 0", imem_bus.req);
    end
    next_cycle(1'b0, 1'b0);
    checks++;
    if (ir !== mem_data(32'h10) || pc_plus4 !== 32'h14 || ir_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL hold_release_ir: got %h/%h/%b expected %h/14/1",
                         ir, pc_plus4, ir_valid, mem_data(32'h10));
    end
    checks++;
    if (imem_bus.addr !== 32'h14 || imem_bus.req !== 1'b1) begin
      errors++; $display("[TB] FAIL hold_next_fetch: got %h/%b expected 14/1", imem_bus.addr, imem_bus.req);
    end
  endtask

  task automatic test_branch_pending();
    scramble = 1'b1;
    mem_wait = 0;
    do_reset();
    for (int c = 1; c <= 7; c++) next_cycle(1'b0, 1'b0);
    mem_wait = 2;
    next_cycle(1'b0, 1'b0);
    checks++;
    if (imem_bus.addr !== 32'h20 || imem_bus.ack !== 1'b0) begin
      errors++; $display("[TB] FAIL br_setup: got addr %h expected 20 pending", imem_bus.addr);
    end
    br_taken  = 1'b1;
    br_target = 32'h0000_0103;
    mem_wait  = 0;
    next_cycle(1'b0, 1'b0);
    checks++;
    if (ir !== 32'h0 || ir_valid !== 1'b0 || imem_bus.addr !== 32'h20) begin
      errors++; $display("[TB] FAIL br_flush: got ir %h valid %b addr %h expected 0/0/20",
                         ir, ir_valid, imem_bus.addr);
    end
    next_cycle(1'b0, 1'b0);
    checks++;
    if (imem_bus.addr !== 32'h20 || ir_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL br_drain: got addr %h valid %b expected 20/0", imem_bus.addr, ir_valid);
    end
    next_cycle(1'b0, 1'b0);
    checks++;
    if (imem_bus.addr !== 32'h100 || ir_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL br_target_fetch: got addr %h valid %b expected 100/0",
                         imem_bus.addr, ir_valid);
    end
    next_cycle(1'b0, 1'b0);
    checks++;
    if (ir !== mem_data(32'h100) || pc_plus4 !== 32'h104 || ir_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL br_target_ir: got %h/%h/%b expected %h/104/1",
                         ir, pc_plus4, ir_valid, mem_data(32'h100));
    end
  endtask

  task automatic test_jump();
    logic [31:0] want;
    scramble = 1'b1;
    mem_wait = 0;
    do_reset();
    jump       = 1'b1;
    jump_index = 26'h40;
    next_cycle(1'b0, 1'b0);
    checks++;
    if (imem_bus.addr !== 32'h4) begin
      errors++; $display("[TB] FAIL jump_ignored_invalid: got %h expected 4", imem_bus.addr);
    end
    for (int v = 0; v < 2; v++) begin
      do_reset();
      br_taken  = 1'b1;
      br_target = 32'h4000_0004;
      next_cycle(1'b0, 1'b0);
      next_cycle(1'b0, 1'b0);
      checks++;
      if (pc_plus4 !== 32'h4000_0008 || ir_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL jump_setup: got %h/%b expected 40000008/1", pc_plus4, ir_valid);
      end
      jump       = 1'b1;
      jump_index = 26'h40;
      want       = 32'h4000_0100;
      if (v == 1) begin
        br_taken  = 1'b1;
        br_target = 32'h0000_0080;
        want      = 32'h0000_0080;
      end
      next_cycle(1'b0, 1'b0);
      checks++;
      if (imem_bus.addr !== want || ir_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL jump_target: variant %0d got %h/%b expected %h/0",
                           v, imem_bus.addr, ir_valid, want);
      end
    end
  endtask

  task automatic test_wrap();
    scramble = 1'b1;
    mem_wait = 0;
    do_reset();
    br_taken  = 1'b1;
    br_target = 32'hFFFF_FFFF;
    next_cycle(1'b0, 1'b0);
    checks++;
    if (imem_bus.addr !== 32'hFFFF_FFFC) begin
      errors++; $display("[TB] FAIL wrap_align: got %h expected fffffffc", imem_bus.addr);
    end
    next_cycle(1'b0, 1'b0);
    checks++;
    if (ir !== mem_data(32'hFFFF_FFFC) || pc_plus4 !== 32'h0 || imem_bus.addr !== 32'h0) begin
      errors++; $display("[TB] FAIL wrap_pc: got ir %h pc4 %h addr %h expected %h/0/0",
                         ir, pc_plus4, imem_bus.addr, mem_data(32'hFFFF_FFFC));
    end
  endtask

  task automatic test_reset_mid_discard();
    scramble = 1'b1;
    mem_wait = 3;
    do_reset();
    br_taken  = 1'b1;
    br_target = 32'h0000_0200;
    next_cycle(1'b0, 1'b0);
    checks++;
    if (imem_bus.addr !== 32'h0 || ir_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL rd_discard: got %h/%b expected 0/0", imem_bus.addr, ir_valid);
    end
    next_cycle(1'b1, 1'b0);
    mem_wait = 0;
    checks++;
    if (imem_bus.req !== 1'b0) begin
      errors++; $display("[TB] FAIL rd_req_low: got %b expected 0", imem_bus.req);
    end
    next_cycle(1'b0, 1'b0);
    checks++;
    if (imem_bus.addr !== RESET_PC || ir_valid !== 1'b0 || imem_bus.req !== 1'b1) begin
      errors++; $display("[TB] FAIL rd_restart: got addr %h valid %b req %b expected %h/0/1",
                         imem_bus.addr, ir_valid, imem_bus.req, RESET_PC);
    end
    next_cycle(1'b0, 1'b0);
    checks++;
    if (ir !== mem_data(RESET_PC) || ir_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL rd_run: got %h/%b expected %h/1", ir, ir_valid, mem_data(RESET_PC));
    end
  endtask

  // Decode must see the instruction stream in program order, restarting at
  // each redirect target, regardless of memory latency or stalls.
  task automatic test_random();
    logic [31:0] exp_next;
    logic [31:0] np4;
    int          accepted;
    bit          redir;
    scramble = 1'b1;
    mem_wait = -1;
    do_reset();
    exp_next = RESET_PC;
    accepted = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst        = 1'b0;
      stall      = ($urandom_range(0, 9) < 3);
      br_taken   = ($urandom_range(0, 19) == 0);
      br_target  = $urandom;
      jump       = ir_valid && ($urandom_range(0, 9) == 0);
      jump_index = 26'($urandom);
      mem_step();
      np4 = exp_next + 32'd4;
      if (ir_valid) begin
        checks++;
        if (ir !== mem_data(exp_next) || pc_plus4 !== np4) begin
          errors++; $display("[TB] FAIL rand_stream: cycle %0d got ir %h pc4 %h expected %h/%h",
                             i, ir, pc_plus4, mem_data(exp_next), np4);
        end
      end else begin
        checks++;
        if (ir !== 32'h0) begin
          errors++; $display("[TB] FAIL rand_nop: cycle %0d got %h expected 0", i, ir);
        end
      end
      redir = br_taken || jump;
      if (redir) begin
        exp_next = br_taken ? (br_target & ~32'h3) : {np4[31:28], jump_index, 2'b00};
      end else if (ir_valid && !stall) begin
        exp_next = np4;
        accepted++;
      end
    end
    checks++;
    if (accepted < 100) begin
      errors++; $display("[TB] FAIL rand_progress: got %0d accepted expected at least 100", accepted);
    end
  endtask

  initial begin
    rst            = 1'b1;
    stall          = 1'b0;
    br_taken       = 1'b0;
    br_target      = 32'h0;
    jump           = 1'b0;
    jump_index     = 26'h0;
    imem_bus.ack   = 1'b0;
    imem_bus.rdata = 32'h0;
    mem_active     = 1'b0;
    wait_left      = 0;
    mem_wait       = 0;
    scramble       = 1'b1;
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall_hold();
    test_branch_pending();
    test_jump();
    test_wrap();
    test_reset_mid_discard();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
